// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : Shared DES key-schedule constants: round count, shift schedule,
//            PC-1 / PC-2 bit tables (FIPS 46-3 numbering), their permutation
//            functions and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int DES_ROUNDS = 16;

    // Left-rotate amount applied to C/D to form C(i+1)/D(i+1), index 0 = round 1
    localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // PC-1: output bit i+1 takes key bit PC1_TABLE[i] (first 28 = C, last 28 = D)
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: subkey bit i+1 takes CD bit PC2_TABLE[i]
    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // FIPS bit n of a vector is stored at [width-n], so the hex MSB is bit 1.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] w_res;
        w_res = '0;
        for (int i = 0; i < 56; i++) begin
            w_res[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
        end
        return w_res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] w_res;
        w_res = '0;
        for (int i = 0; i < 48; i++) begin
            w_res[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
        end
        return w_res;
    endfunction

endpackage : des_pkg
`default_nettype wire

// File: rtl/des_cd_rotate.sv
`default_nettype none
// ============================================================================
// Module   : des_cd_rotate
// Purpose  : Combinational 28-bit rotate of one DES key half by 1 or 2
//            positions. Left rotation moves FIPS bit 1 (the MSB) to the end.
//            Right rotation and its direction port exist only when
//            DES_KEY_DECRYPT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module des_cd_rotate
    import des_pkg::*;
(
    input  logic [27:0] din,
    input  logic        two,
`ifdef DES_KEY_DECRYPT_EN
    input  logic        right,
`endif
    output logic [27:0] dout
);

    // Select rotation amount (and direction when decryption is built in)
    always_comb begin
        dout = two ? {din[25:0], din[27:26]} : {din[26:0], din[27]};
`ifdef DES_KEY_DECRYPT_EN
        if (right) begin
            dout = two ? {din[1:0], din[27:2]} : {din[0], din[27:1]};
        end
`endif
    end

endmodule : des_cd_rotate
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : des_key_sched
// Purpose  : Sequential DES key-schedule controller. Applies PC-1 once on
//            start, steps C/D through the 16-round shift schedule and
//            presents one PC-2 subkey per accepted valid/ready beat.
//            DES_KEY_DECRYPT_EN adds the decrypt port (K16..K1 order with
//            right rotations); without it only encrypt order is built.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_sched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
`ifdef DES_KEY_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        done
);

    localparam logic [3:0] c_LAST_ROUND = 4'(DES_ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [55:0] r_cd;
    logic [3:0]  r_round;
    logic        r_done;

    logic        w_accept;
    logic        w_beat;
    logic        w_last;
    logic [3:0]  w_shift_idx;
    logic [3:0]  w_round_next;
    logic [55:0] w_pc1;
    logic [55:0] w_rot_src;
    logic [55:0] w_rot_out;
    logic        w_rot_two;
    logic        w_dec;
    logic        w_dec_req;

`ifdef DES_KEY_DECRYPT_EN
    logic        r_dec;
    logic        w_rot_right;

    assign w_dec       = r_dec;
    assign w_dec_req   = decrypt;
    assign w_rot_right = (r_state == RUN) && r_dec;
`else
    assign w_dec       = 1'b0;
    assign w_dec_req   = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_beat   = (r_state == RUN) && subkey_ready;
    assign w_last   = w_dec ? (r_round == 4'd0) : (r_round == c_LAST_ROUND);
    assign w_pc1    = pc1(key);

    // Encrypt uses the shift that forms the next round; decrypt undoes the
    // shift that formed the current round.
    assign w_shift_idx = w_dec ? r_round : r_round + 4'd1;

    // In IDLE the rotator produces rotl(PC1(key), 1) for the first encrypt key
    always_comb begin
        w_rot_src = r_cd;
        w_rot_two = (SHIFT_SCHED[w_shift_idx] == 2);
        if (r_state == IDLE) begin
            w_rot_src = w_pc1;
            w_rot_two = 1'b0;
        end
    end

    // Next round index: down-count only exists with decryption built in
    always_comb begin
        w_round_next = r_round + 4'd1;
`ifdef DES_KEY_DECRYPT_EN
        if (r_dec) begin
            w_round_next = r_round - 4'd1;
        end
`endif
    end

    des_cd_rotate u_rot_c (
        .din   (w_rot_src[55:28]),
        .two   (w_rot_two),
`ifdef DES_KEY_DECRYPT_EN
        .right (w_rot_right),
`endif
        .dout  (w_rot_out[55:28])
    );

    des_cd_rotate u_rot_d (
        .din   (w_rot_src[27:0]),
        .two   (w_rot_two),
`ifdef DES_KEY_DECRYPT_EN
        .right (w_rot_right),
`endif
        .dout  (w_rot_out[27:0])
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: start only matters in IDLE, final beat returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_beat && w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // C/D, round counter and done pulse; all hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cd    <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
            r_dec   <= 1'b0;
`endif
        end else begin
            r_done <= w_beat && w_last;
            if (w_accept) begin
`ifdef DES_KEY_DECRYPT_EN
                r_dec   <= w_dec_req;
                r_cd    <= w_dec_req ? w_pc1 : w_rot_out;
                r_round <= w_dec_req ? c_LAST_ROUND : 4'd0;
`else
                r_cd    <= w_rot_out;
                r_round <= 4'd0;
`endif
            end else if (w_beat && !w_last) begin
                r_cd    <= w_rot_out;
                r_round <= w_round_next;
            end
        end
    end

    assign busy         = (r_state == RUN);
    assign subkey_valid = (r_state == RUN);
    assign subkey       = pc2(r_cd);
    assign round        = r_round;
    assign done         = r_done;

`ifndef DES_KEY_DECRYPT_EN
    logic w_unused;
    assign w_unused = w_dec_req;
`endif

endmodule : des_key_sched
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_sched
// Purpose  : Self-checking bench for des_key_sched: known-answer vector
//            table, hand-written stall / restart / reset sequences and
//            randomized schedules against a bit-level key-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key;
`ifdef DES_KEY_DECRYPT_EN
    logic        decrypt;
`endif
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key          (key),
`ifdef DES_KEY_DECRYPT_EN
        .decrypt      (decrypt),
`endif
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .done         (done)
    );

    // Reference tables (FIPS 46-3)
    int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_ks [16];
    logic [47:0] obs_ks [16];

    typedef struct {
        logic [63:0] key;
        int          idx;
        logic [47:0] sk;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Key schedule from first principles: C_i/D_i are C0/D0 rotated left by
    // the cumulative shift count, then PC-2 picks the subkey bits.
    task automatic build_model(input logic [63:0] k);
        bit kb [1:64];
        bit c0 [28];
        bit d0 [28];
        bit cd [1:56];
        int cum;
        for (int i = 1; i <= 64; i++) kb[i] = k[64 - i];
        for (int j = 0; j < 28; j++) begin
            c0[j] = kb[PC1[j]];
            d0[j] = kb[PC1[j + 28]];
        end
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SH[r];
            for (int j = 0; j < 28; j++) begin
                cd[j + 1]  = c0[(j + cum) % 28];
                cd[j + 29] = d0[(j + cum) % 28];
            end
            for (int i = 0; i < 48; i++) exp_ks[r][47 - i] = cd[PC2[i]];
        end
    endtask

    // mode 0: ready always 1, 1: ready toggles starting high, 2: random ready.
    // poke >= 0 pulses start with key alt while the subkey of that beat is shown.
    task automatic run_sched(input logic [63:0] k, input bit dec, input int mode,
                             input int poke, input logic [63:0] alt, output int latency);
        int n;
        int cyc;
        int idx;
        bit rdy;
        bit poked;
        build_model(k);
        check("idle_before_start", 64'({busy, subkey_valid, done}), 64'd0);
        key = k;
`ifdef DES_KEY_DECRYPT_EN
        decrypt = dec;
`endif
        start = 1'b1;
        subkey_ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 1;
        n = 0;
        poked = 1'b0;
        while (n < 16 && cyc < 200) begin
            idx = dec ? 15 - n : n;
            check("run_flags", 64'({busy, subkey_valid, done}), 64'b110);
            check("subkey", 64'(subkey), 64'(exp_ks[idx]));
            check("round", 64'(round), 64'(idx));
            obs_ks[idx] = subkey;
            start = 1'b0;
            key = k;
            if (n == poke && !poked) begin
                start = 1'b1;
                key = alt;
                poked = 1'b1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            subkey_ready = rdy;
            step();
            cyc++;
            if (rdy) n++;
        end
        start = 1'b0;
        key = k;
        subkey_ready = 1'b0;
        check("beats_within_budget", 64'(n), 64'd16);
        check("done_pulse", 64'({busy, subkey_valid, done}), 64'b001);
        latency = cyc;
        step();
        check("done_one_cycle", 64'({busy, subkey_valid, done}), 64'd0);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] k1;
        logic [63:0] k2;
        logic [63:0] rk;
        bit rdec;

        vecs[0] = '{64'h133457799BBCDFF1, 0,  48'h1B02EFFC7072};
        vecs[1] = '{64'h133457799BBCDFF1, 1,  48'h79AED9DBC9E5};
        vecs[2] = '{64'h133457799BBCDFF1, 2,  48'h55FC8A42CF99};
        vecs[3] = '{64'h133457799BBCDFF1, 15, 48'hCB3D8B0E17F5};
        vecs[4] = '{64'h0101010101010101, 0,  48'h000000000000};
        vecs[5] = '{64'h0101010101010101, 9,  48'h000000000000};
        vecs[6] = '{64'hFEFEFEFEFEFEFEFE, 0,  48'hFFFFFFFFFFFF};
        vecs[7] = '{64'hFFFFFFFFFFFFFFFF, 15, 48'hFFFFFFFFFFFF};

        k1 = 64'h133457799BBCDFF1;
        k2 = 64'h0E329232EA6D0D73;

        rst = 1'b1;
        start = 1'b0;
        subkey_ready = 1'b0;
        key = '0;
`ifdef DES_KEY_DECRYPT_EN
        decrypt = 1'b0;
`endif
        step();
        step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(subkey_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_round", 64'(round), 64'd0);
        check("reset_subkey", 64'(subkey), 64'd0);
        rst = 1'b0;
        step();

        // Known-answer table, ready held high
        for (int i = 0; i < 8; i++) begin
            run_sched(vecs[i].key, 1'b0, 0, -1, 64'd0, lat);
            check("vec_subkey", 64'(obs_ks[vecs[i].idx]), 64'(vecs[i].sk));
            check("vec_done_latency", 64'(lat), 64'd17);
        end

        // Ready toggling 1/0: every subkey held through its stall cycle
        run_sched(k1, 1'b0, 1, -1, 64'd0, lat);
        check("toggle_done_latency", 64'(lat), 64'd32);

        // Start with another key at round 7 must be ignored
        run_sched(k1, 1'b0, 0, 7, k2, lat);
        check("poke_done_latency", 64'(lat), 64'd17);
        check("poke_k16", 64'(obs_ks[15]), 64'hCB3D8B0E17F5);

`ifdef DES_KEY_DECRYPT_EN
        run_sched(k1, 1'b1, 0, -1, 64'd0, lat);
        check("dec_done_latency", 64'(lat), 64'd17);
        check("dec_first_k16", 64'(obs_ks[15]), 64'hCB3D8B0E17F5);
        check("dec_last_k1", 64'(obs_ks[0]), 64'h1B02EFFC7072);
`endif

        // Randomized keys and ready patterns
        for (int r = 0; r < 6; r++) begin
            rk = {32'($urandom), 32'($urandom)};
`ifdef DES_KEY_DECRYPT_EN
            rdec = 1'($urandom_range(0, 1));
`else
            rdec = 1'b0;
`endif
            run_sched(rk, rdec, 2, -1, 64'd0, lat);
        end

        // start held high: key changed mid-run is taken only at T+17
        build_model(k1);
        key = k1;
        start = 1'b1;
        subkey_ready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            check("held_subkey", 64'(subkey), 64'(exp_ks[i]));
            check("held_flags", 64'({busy, subkey_valid, done}), 64'b110);
            if (i == 8) key = k2;
            step();
        end
        check("held_done_t17", 64'({busy, subkey_valid, done}), 64'b001);
        build_model(k2);
        step();
        check("held_restart_flags", 64'({busy, subkey_valid, done}), 64'b110);
        check("held_restart_round", 64'(round), 64'd0);
        check("held_restart_subkey", 64'(subkey), 64'(exp_ks[0]));
        start = 1'b0;

        // Reset in the middle of the schedule at round 5
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_round", 64'(round), 64'd5);
        rst = 1'b1;
        #1;
        check("midrst_flags", 64'({busy, subkey_valid, done}), 64'd0);
        check("midrst_round", 64'(round), 64'd0);
        check("midrst_subkey", 64'(subkey), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("post_rst_idle", 64'({busy, subkey_valid, done}), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_des_key_sched
`default_nettype wire

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key-schedule controller. It accepts a 64-bit key, applies PC-1 once, then steps the C/D halves through the 16-round shift schedule and presents one PC-2 subkey per round on a valid/ready interface. It sits between the key input and the round-function datapath, which consumes K1..K16 (or K16..K1 for decryption) one per accepted beat.

## Interface
- No parameters. Round count (16) and shift schedule are fixed package constants.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a new schedule; accepted only when busy=0
- key  in  64 [64:1]  DES key, index 1 = FIPS bit 1; parity bits (8,16,..,64) ignored
- decrypt  in  1  sampled with start; 1 = emit K16..K1 (present only with DES_KEY_DECRYPT_EN)
- busy  out  1  schedule in progress
- subkey_valid  out  1  subkey holds a valid round key
- subkey_ready  in  1  consumer accepts subkey this cycle
- subkey  out  48 [48:1]  PC-2 of current C/D registers, index 1 = FIPS bit 1
- round  out  4  round index of current subkey, 0..15 (K1 = 0)
- done  out  1  one-cycle pulse after 16th subkey accepted

## Operation
- State machine: IDLE, RUN.
- IDLE: busy=0, subkey_valid=0. start=1 → latch CD, go RUN.
  - Encrypt: CD ← rotl(PC1(key), 1) per half, round ← 0.
  - Decrypt: CD ← PC1(key) unrotated (C16=C0), round ← 15.
- RUN: busy=1, subkey_valid=1, subkey = PC2(C,D) combinationally from registers.
  - Beat = subkey_valid & subkey_ready.
  - Encrypt beat, round<15: round+1; each 28-bit half rotl by s[round+1].
  - Decrypt beat, round>0: round−1; each half rotr by s[round].
  - Shift schedule s[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Beat on final round (15 encrypt / 0 decrypt): go IDLE, done=1 next cycle.
- subkey_ready low: subkey, round, CD held stable; no timeout.
- start while busy=1: ignored, no effect.
- C = CD[1:28], D = CD[29:56] in FIPS numbering; rotations never cross halves.
- Reset values: busy 0, subkey_valid 0, done 0, round 0, CD 0 (so subkey 0), state IDLE.
- rst mid-schedule: all outputs return to reset values immediately; partial schedule discarded, no done.

## Timing
- start accepted cycle T → subkey_valid=1 with first key at T+1 (latency 1).
- subkey_ready held 1: Ki at T+i, i=1..16; done=1, busy=0 at T+17.
- start=1 at T+17 is accepted (IDLE); back-to-back schedules spaced 17 cycles.
- Each ready-low cycle delays all later beats and done by one cycle.
- done never coincides with subkey_valid.

## Configuration
- DES_KEY_DECRYPT_EN defined: decrypt port present; reverse order and right rotations implemented.
- Undefined: no decrypt port; encrypt-order only, right-rotate logic absent; round only increments.

## Structure
- Package des_pkg: DES_ROUNDS=16, shift-schedule constant array, PC-1 and PC-2 permutation functions (FIPS bit tables), state enum {IDLE, RUN}.
- One sub-module des_cd_rotate: combinational 28-bit rotate by 1 or 2, direction input; instantiated twice (C, D).
- FSM, round counter, handshake in top module.

## Test plan
- Reset mid-RUN (round 5): rst high → busy, subkey_valid, done, round, subkey all 0 same cycle; IDLE after release.
- key=0x133457799BBCDFF1, ready=1, start at T → T+1 subkey=0x1B02EFFC7072 round 0; T+16 subkey=0xCB3D8B0E17F5 round 15; done at T+17.
- Same key, ready toggled 1/0 each cycle → same 16 subkeys in order, each held while ready=0; done at T+32.
- Decrypt (DES_KEY_DECRYPT_EN), same key → first subkey 0xCB3D8B0E17F5 round 15, last 0x1B02EFFC7072 round 0.
- start pulsed at round 7 with different key → ignored; sequence continues unchanged.
- start held high continuously → new schedule accepted at T+17, first key at T+18; done one-cycle only.
